// File: rtl/aes_pkg.sv
// Shared definitions for the AES plaintext/ciphertext DMA stages.
// Holds the sequencer state encoding and the AES slave register map.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          BLOCK_WORDS   = 4;
    localparam logic [3:0]  AES_PT_ADDR   = 4'h0;
    localparam logic [3:0]  AES_CT_ADDR   = 4'h4;
    localparam logic [3:0]  AES_STAT_ADDR = 4'h8;

endpackage

// File: rtl/aes_plain_dma_if.sv
// Bus bundle for the plaintext DMA: Avalon-MM memory read master plus
// the Avalon-MM write master that targets the AES slave.
interface aes_plain_dma_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic [31:0]       m_readdata;
    logic              m_waitrequest;
    logic              a_chipselect;
    logic [3:0]        a_address;
    logic              a_write;
    logic [31:0]       a_writedata;
    logic              a_waitrequest;

    modport master (
        output m_address, m_read,
        input  m_readdata, m_waitrequest,
        output a_chipselect, a_address, a_write, a_writedata,
        input  a_waitrequest
    );

    modport slave (
        input  m_address, m_read,
        output m_readdata, m_waitrequest,
        input  a_chipselect, a_address, a_write, a_writedata,
        output a_waitrequest
    );
endinterface

// File: rtl/aes_plain_dma.sv
// Plaintext DMA: fetches whole 128-bit blocks from memory and pushes each
// one into the AES plaintext register as four 32-bit writes.
//
// state   | meaning
// IDLE    | waiting for start
// RD      | reading the four words of one block into the buffer
// WR      | writing the buffered block to the AES plaintext register
// DONE    | job finished (normal or aborted), one cycle then IDLE
module aes_plain_dma #(
    parameter int         ADDR_W      = 32,
    parameter int         CNT_W       = 16,
    parameter logic [3:0] AES_PT_ADDR = aes_pkg::AES_PT_ADDR
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blocks_done,
    aes_plain_dma_if.master   bus
);
    import aes_pkg::*;

    state_t            state_q;
    state_t            state_nx;
    logic [1:0]        widx;
    logic [1:0]        widx_inc;
    logic [31:0]       blk_buf [BLOCK_WORDS];
    logic [CNT_W-1:0]  num_q;
    logic              rd_acc;
    logic              wr_acc;
    logic              last_word;
    logic              last_block;

    always_comb begin
        state_nx   = state_q;
        rd_acc     = (state_q == ST_RD) && !bus.m_waitrequest;
        wr_acc     = (state_q == ST_WR) && !bus.a_waitrequest;
        last_word  = (widx == 2'(BLOCK_WORDS - 1));
        last_block = ((blocks_done + CNT_W'(1)) == num_q);
        widx_inc   = widx + 2'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (num_blocks != '0) ? ST_RD : ST_DONE;
                end
            end
            ST_RD: begin
                if (rd_acc && last_word) begin
                    state_nx = ST_WR;
                end
            end
            ST_WR: begin
                // abort is only honoured once a whole block has landed in the AES
                if (wr_acc && last_word) begin
                    state_nx = (last_block || abort) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Every output is a flop; bus strobes are loaded from the next state so
    // the first read issues the cycle after start.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            blocks_done      <= '0;
            num_q            <= '0;
            widx             <= '0;
            bus.m_address    <= '0;
            bus.m_read       <= 1'b0;
            bus.a_chipselect <= 1'b0;
            bus.a_address    <= '0;
            bus.a_write      <= 1'b0;
            bus.a_writedata  <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                blk_buf[i] <= '0;
            end
        end else begin
            busy             <= (state_nx != ST_IDLE);
            done             <= (state_q == ST_DONE);
            bus.m_read       <= (state_nx == ST_RD);
            bus.a_write      <= (state_nx == ST_WR);
            bus.a_chipselect <= (state_nx == ST_WR);
            bus.a_address    <= (state_nx == ST_WR) ? AES_PT_ADDR : 4'h0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bus.m_address <= {src_addr[ADDR_W-1:2], 2'b00};
                        num_q         <= num_blocks;
                        blocks_done   <= '0;
                        widx          <= '0;
                    end
                end
                ST_RD: begin
                    if (rd_acc) begin
                        blk_buf[widx] <= bus.m_readdata;
                        bus.m_address <= bus.m_address + ADDR_W'(4);
                        widx          <= widx_inc;
                        if (last_word) begin
                            bus.a_writedata <= blk_buf[0];
                        end
                    end
                end
                ST_WR: begin
                    if (wr_acc) begin
                        widx <= widx_inc;
                        if (last_word) begin
                            blocks_done <= blocks_done + CNT_W'(1);
                        end else begin
                            bus.a_writedata <= blk_buf[widx_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
